// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_LAT_W  = 4;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic                   we;
    logic [31:0]            addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic dmem_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read. Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [DMEM_DATA_W-1:0]         wdata_i,
  output logic [DMEM_DATA_W-1:0]         rdata_o
);

  logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[idx_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready request and one-cycle response.
// Optional misaligned-access reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o
);

  localparam int unsigned            IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_LAT_W-1:0]  LAT_LOAD = DMEM_LAT_W'(LATENCY - 1);

  dmem_state_e            state;
  logic [DMEM_LAT_W-1:0]  lat_cnt;
  dmem_req_t              req_q;
  dmem_req_t              acc;
  logic                   accept;
  logic                   go_resp;
  logic                   acc_err;
  logic                   rsp_load_q;
  logic                   arr_we;
  logic                   arr_re;
  logic [DMEM_DATA_W-1:0] arr_rdata;
  logic                   unused_addr;

  // With LATENCY=1 the RESP edge is also the accept edge, so the array must
  // see the live request instead of the not-yet-latched copy.
  always_comb begin
    acc = req_q;
    if (state == IDLE) begin
      acc.we    = req_we_i;
      acc.addr  = req_addr_i;
      acc.wdata = req_wdata_i;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = dmem_misaligned(acc.addr[1:0]);
`else
  assign acc_err = 1'b0;
`endif

  assign accept = rst_i && (state == IDLE) && req_valid_i;

  always_comb begin
    go_resp = 1'b0;
    if (state == IDLE) begin
      go_resp = accept && (LATENCY == 1);
    end else if (state == WAIT) begin
      go_resp = (lat_cnt == DMEM_LAT_W'(1));
    end
  end

  assign arr_we = rst_i && go_resp && acc.we && !acc_err;
  assign arr_re = go_resp && !acc.we && !acc_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      req_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      rsp_valid_o <= go_resp;
      rsp_err_o   <= go_resp && acc_err;
      rsp_load_q  <= arr_re;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_q   <= acc;
            lat_cnt <= LAT_LOAD;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - DMEM_LAT_W'(1);
          if (go_resp) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (acc.addr[IDX_W+1:2]),
    .wdata_i (acc.wdata),
    .rdata_o (arr_rdata)
  );

  // Read data is only presented during the response cycle of a good load.
  assign rsp_rdata_o = rsp_load_q ? arr_rdata : '0;
  assign req_ready_o = rst_i && (state == IDLE);
  assign stall_o     = accept || (state == WAIT);

  assign unused_addr = ^{acc.addr[31:IDX_W+2], acc.addr[1:0]};

endmodule
